// File: rtl/mesh_run_ctrl.sv
// mesh_run_ctrl: loads mesh_inp, drives mesh_high for iters cycles, captures mesh_out, streams it out 32 bits/word (rd_ready stalls hold data).
// First rd_valid at start+iters+PIPE_LAT+2; MESH_RUN_CTRL_PARITY_EN appends an XOR parity word after the 59 data words.
module mesh_run_ctrl #(
  parameter int ITER_W   = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_data,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [935:0]      mesh_inp,
  output logic              mesh_high,
  input  logic [1871:0]     mesh_out,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              rd_last
);

`ifdef MESH_RUN_CTRL_PARITY_EN
  localparam logic [5:0] LAST_IDX = 6'd59;
`else
  localparam logic [5:0] LAST_IDX = 6'd58;
`endif

  typedef enum logic [2:0] {IDLE, RUN, WAIT, CAPTURE, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [4:0]         ptr;
  logic               loaded;
  logic [ITER_W-1:0]  cnt;
  logic [5:0]         idx;
  logic [1855:0]      res_buf;
  logic               cfg_hs, rd_hs, load_ok, go;
`ifdef MESH_RUN_CTRL_PARITY_EN
  logic [31:0]        par;
`endif

  assign cfg_ready = (state == IDLE);
  assign rd_valid  = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign mesh_high = (state == RUN);
  assign cfg_hs    = cfg_valid & cfg_ready;
  assign rd_hs     = rd_valid & rd_ready;
  // A word accepted alongside start is counted before start is judged.
  assign load_ok   = (cfg_hs && ptr == 5'd29) || (loaded && !(cfg_hs && ptr == 5'd0));
  assign go        = cfg_ready & start & load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = (iters == '0) ? WAIT : RUN;
      RUN:     if (cnt <= ITER_W'(1)) state_nxt = WAIT;
      WAIT:    if (cnt <= ITER_W'(1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = DRAIN;
      DRAIN:   if (rd_hs && idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      loaded   <= 1'b0;
      mesh_inp <= '0;
      err      <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      res_buf  <= '0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
`ifdef MESH_RUN_CTRL_PARITY_EN
      par      <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (cfg_hs) begin
        for (int k = 0; k < 29; k++)
          if (ptr == 5'(k)) mesh_inp[32*k +: 32] <= cfg_data;
        if (ptr == 5'd29) begin
          mesh_inp[935:928] <= cfg_data[7:0];
          loaded            <= 1'b1;
          ptr               <= '0;
        end else begin
          ptr <= ptr + 5'd1;
          if (ptr == 5'd0) loaded <= 1'b0;
        end
      end
      if (cfg_ready && start && !load_ok) err <= 1'b1;

      case (state)
        IDLE: if (go) cnt <= (iters == '0) ? ITER_W'(PIPE_LAT) : iters;
        RUN:  cnt <= (cnt <= ITER_W'(1)) ? ITER_W'(PIPE_LAT) : cnt - 1'b1;
        WAIT: cnt <= cnt - 1'b1;
        CAPTURE: begin
          // Word 0 goes straight to rd_data; the rest shift down one word per handshake.
          res_buf <= {16'h0, mesh_out[1871:32]};
          rd_data <= mesh_out[31:0];
          rd_last <= 1'b0;
          idx     <= '0;
`ifdef MESH_RUN_CTRL_PARITY_EN
          par     <= '0;
`endif
        end
        DRAIN: if (rd_hs) begin
`ifdef MESH_RUN_CTRL_PARITY_EN
          par <= par ^ rd_data;
`endif
          if (idx == LAST_IDX) begin
            rd_data <= '0;
            rd_last <= 1'b0;
            done    <= 1'b1;
          end else begin
            idx     <= idx + 6'd1;
            rd_last <= ((idx + 6'd1) == LAST_IDX);
            res_buf <= res_buf >> 32;
`ifdef MESH_RUN_CTRL_PARITY_EN
            if (idx == 6'd58) rd_data <= par ^ rd_data;
            else              rd_data <= res_buf[31:0];
`else
            rd_data <= res_buf[31:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_run_ctrl.sv
// Bench for mesh_run_ctrl: table of run vectors with a read-word scoreboard, plus hand sequences for error, stall and reset cases.
module tb_mesh_run_ctrl;
  localparam int ITER_W   = 16;
  localparam int PIPE_LAT = 2;
`ifdef MESH_RUN_CTRL_PARITY_EN
  localparam int NW = 60;
`else
  localparam int NW = 59;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [31:0]       cfg_data = '0;
  logic              start = 1'b0;
  logic [ITER_W-1:0] iters = '0;
  logic              busy, done, err, mesh_high;
  logic [935:0]      mesh_inp;
  logic [1871:0]     mesh_out = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [31:0]       rd_data;
  logic              rd_last;

  int checks = 0;
  int errors = 0;
  logic [935:0] exp_inp = '0;
  logic [32:0]  sb[$];

  typedef struct {
    logic [ITER_W-1:0] it;
    logic [31:0]       pat;
    int                mode;
    bit                reload;
    logic [31:0]       base;
    int                exp_high;
    int                exp_lat;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  mesh_run_ctrl #(.ITER_W(ITER_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .start(start), .iters(iters),
    .busy(busy), .done(done), .err(err),
    .mesh_inp(mesh_inp), .mesh_high(mesh_high), .mesh_out(mesh_out),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_inp(input string name, input logic [935:0] exp);
    logic [31:0] a, e;
    int first;
    checks++;
    first = -1;
    for (int k = 29; k >= 0; k--) begin
      a = 32'(mesh_inp[32*k +: 8]);
      if (k < 29) a = mesh_inp[32*k +: 32];
      e = (k < 29) ? exp[32*k +: 32] : 32'(exp[935:928]);
      if (a !== e) first = k;
    end
    if (first >= 0) begin
      errors++;
      if (first < 29) begin
        a = mesh_inp[32*first +: 32];
        e = exp[32*first +: 32];
      end else begin
        a = 32'(mesh_inp[935:928]);
        e = 32'(exp[935:928]);
      end
      $display("FAIL %s word %0d: actual %0h, expected %0h", name, first, a, e);
    end
  endtask

  task automatic load(input logic [31:0] base);
    logic [31:0] w;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = base + 32'(k);
      w = cfg_data;
      if (k < 29) exp_inp[32*k +: 32] = w;
      else        exp_inp[935:928]    = w[7:0];
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    chk_inp("mesh_inp_load", exp_inp);
  endtask

  task automatic run_vec(input vec_t v);
    logic [1887:0] img;
    logic [31:0]   w, par, hold_d, e32;
    logic          hold_l;
    logic [32:0]   e;
    int            highs, lat, rc;
    bit            stalled, got_last;
    img = '0;
    for (int j = 0; j < 58; j++) img[32*j +: 32] = v.pat + 32'(j);
    e32 = v.pat + 32'd58;
    img[1887:1856] = {16'h0, e32[15:0]};
    mesh_out = img[1871:0];
    par = '0;
    for (int j = 0; j < 59; j++) begin
      w = img[32*j +: 32];
      par ^= w;
      sb.push_back({(j == NW - 1), w});
    end
`ifdef MESH_RUN_CTRL_PARITY_EN
    sb.push_back({1'b1, par});
`endif
    @(negedge clk);
    start = 1'b1;
    iters = v.it;
    @(negedge clk);
    start = 1'b0;
    highs = 0;
    lat   = 0;
    for (int n = 1; n <= 200 && lat == 0; n++) begin
      if (mesh_high) highs++;
      if (rd_valid) lat = n;
      else @(negedge clk);
    end
    chk("high_cycles", highs, v.exp_high);
    chk("first_valid_latency", lat, v.exp_lat);

    rc = 0;
    stalled = 0;
    got_last = 0;
    hold_d = '0;
    hold_l = 1'b0;
    for (int c = 0; c < 400 && !got_last; c++) begin
      if (c > 0) @(negedge clk);
      rd_ready = (v.mode == 0) || (rc % 3 == 0);
      if (rd_valid) begin
        if (stalled) begin
          chk("stall_data", rd_data, hold_d);
          chk("stall_last", rd_last, hold_l);
        end
        if (rd_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: actual %0h, expected no word", rd_data);
          end else begin
            e = sb.pop_front();
            chk("rd_data", rd_data, e[31:0]);
            chk("rd_last", rd_last, e[32]);
            if (e[32]) begin
              got_last = 1;
              chk("done_before_last_hs", done, 0);
            end
          end
          stalled = 0;
        end else begin
          stalled = 1;
          hold_d = rd_data;
          hold_l = rd_last;
        end
        rc++;
      end
    end
    if (!got_last) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual %0d words left, expected 0", sb.size());
    end
    @(negedge clk);
    rd_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_after_drain", busy, 0);
    chk("words_remaining", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    tbl[0] = '{it: 16'd3, pat: 32'h1234_5678, mode: 0, reload: 1'b1, base: 32'hA5A5_0000, exp_high: 3, exp_lat: 7};
    tbl[1] = '{it: 16'd5, pat: 32'hDEAD_BEEF, mode: 1, reload: 1'b0, base: 32'h0,         exp_high: 5, exp_lat: 9};
    tbl[2] = '{it: 16'd0, pat: 32'h0F0F_F0F0, mode: 0, reload: 1'b1, base: 32'h3C3C_0100, exp_high: 0, exp_lat: 4};
    tbl[3] = '{it: 16'd1, pat: 32'hFFFF_FFF0, mode: 1, reload: 1'b0, base: 32'h0,         exp_high: 1, exp_lat: 5};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mesh_high", mesh_high, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_last", rd_last, 0);
    chk_inp("rst_mesh_inp", '0);

    // start with nothing loaded is refused and flags err
    start = 1'b1;
    iters = 16'd3;
    @(negedge clk);
    start = 1'b0;
    chk("unloaded_start_busy", busy, 0);
    chk("unloaded_start_err", err, 1);
    @(negedge clk);
    chk("unloaded_start_idle", cfg_ready, 1);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].reload) load(tbl[i].base);
      else chk_inp("mesh_inp_retained", exp_inp);
      run_vec(tbl[i]);
      chk("err_sticky", err, 1);
    end

    // fresh reset: start/cfg while running are ignored, then reset mid-drain
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_err", err, 0);
    load(32'h5500_0000);
    mesh_out = '0;
    @(negedge clk);
    start = 1'b1;
    iters = 16'd4;
    @(negedge clk);
    start = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_mesh_high", mesh_high, 1);
    start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("run_cfg_ready", cfg_ready, 0);
    start = 1'b0;
    for (int i = 0; i < 50 && !rd_valid; i++) @(negedge clk);
    chk("busy_start_no_err", err, 0);
    chk("reach_drain", rd_valid, 1);
    chk_inp("cfg_held_not_taken", exp_inp);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_drain_rst_rd_valid", rd_valid, 0);
    chk("mid_drain_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_inp("rst3_mesh_inp", '0);

    // a new word 0 after a full load clears loaded
    load(32'h7700_0000);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data = 32'h1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b1;
    iters = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("reload_start_busy", busy, 0);
    chk("reload_start_err", err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
